// File: rtl/memu_ooo_buffer.sv
// MEM stage with an in-order buffer of up to DEPTH outstanding data-SRAM requests.
// Non-loads reach WB the cycle after push, loads the cycle after their data_ok; pop waits on wb_allowin.
module memu_ooo_buffer #(
    parameter int DEPTH     = 4,
    parameter int PAYLOAD_W = 128
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_allowin,
    input  logic                 in_wait_data,
    input  logic                 in_res_from_mem,
    input  logic [3:0]           in_mem_op,
    input  logic [31:0]          in_alu_result,
    input  logic                 in_rf_we,
    input  logic [4:0]           in_rf_waddr,
    input  logic                 in_ex,
    input  logic [PAYLOAD_W-1:0] in_payload,
    input  logic                 data_sram_data_ok,
    input  logic [31:0]          data_sram_rdata,
    output logic                 out_valid,
    input  logic                 wb_allowin,
    output logic                 out_rf_we,
    output logic [4:0]           out_rf_waddr,
    output logic [31:0]          out_rf_wdata,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic                 mem_ex,
    input  logic [4:0]           fwd_raddr1,
    input  logic [4:0]           fwd_raddr2,
    output logic                 fwd_hit1,
    output logic                 fwd_hit2,
    output logic                 fwd_stall1,
    output logic                 fwd_stall2,
    output logic [31:0]          fwd_data1,
    output logic [31:0]          fwd_data2
);
    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] wr_ptr, rd_ptr, rsp_ptr;
    logic [AW:0]   count, discard_cnt;

    logic [DEPTH-1:0]     e_wait, e_got, e_load, e_we, e_ex;
    logic [3:0]           e_op      [DEPTH];
    logic [1:0]           e_lane    [DEPTH];
    logic [4:0]           e_waddr   [DEPTH];
    logic [31:0]          e_wdata   [DEPTH];
    logic [PAYLOAD_W-1:0] e_payload [DEPTH];

    logic [DEPTH-1:0] valid;
    logic             rsp_found;
    logic [AW-1:0]    rsp_idx;
    logic [AW:0]      pend;
    logic             head_ready, push, pop, dok_discard, dok_entry;
    logic [31:0]      ld_ext;

    function automatic logic [31:0] load_extract(input logic [3:0] op, input logic [1:0] lane,
                                                 input logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(d >> {lane, 3'b000});
        h = lane[1] ? d[31:16] : d[15:0];
        case (op)
            4'd0:    load_extract = {{24{b[7]}}, b};
            4'd8:    load_extract = {24'b0, b};
            4'd1:    load_extract = {{16{h[15]}}, h};
            4'd9:    load_extract = {16'b0, h};
            4'd2:    load_extract = d;
            default: load_extract = 32'b0;
        endcase
    endfunction

    always_comb begin
        valid = '0;
        pend  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if ((AW+1)'(k) < count) valid[rd_ptr + AW'(k)] = 1'b1;
        end
        for (int i = 0; i < DEPTH; i++) begin
            pend = pend + (AW+1)'(valid[i] & e_wait[i] & ~e_got[i]);
        end
    end

    // Responses are in order, so the nearest outstanding entry at or after rsp_ptr owns the next data_ok.
    always_comb begin
        rsp_found = 1'b0;
        rsp_idx   = rsp_ptr;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (valid[rsp_ptr + AW'(k)] & e_wait[rsp_ptr + AW'(k)] & ~e_got[rsp_ptr + AW'(k)]) begin
                rsp_found = 1'b1;
                rsp_idx   = rsp_ptr + AW'(k);
            end
        end
    end

    assign head_ready  = ~e_wait[rd_ptr] | e_got[rd_ptr];
    assign out_valid   = (count != '0) & head_ready;
    assign out_rf_we   = e_we[rd_ptr];
    assign out_rf_waddr = e_waddr[rd_ptr];
    assign out_rf_wdata = e_wdata[rd_ptr];
    assign out_payload = e_payload[rd_ptr];
    assign pop         = out_valid & wb_allowin;
    assign in_allowin  = (({1'b0, count} + {1'b0, discard_cnt}) < (AW+2)'(DEPTH)) | pop;
    assign push        = in_valid & in_allowin & ~flush;
    assign dok_discard = data_sram_data_ok & (discard_cnt != '0);
    assign dok_entry   = data_sram_data_ok & (discard_cnt == '0) & rsp_found;
    assign ld_ext      = load_extract(e_op[rsp_idx], e_lane[rsp_idx], data_sram_rdata);
    assign mem_ex      = |(valid & e_ex);

    // Oldest to youngest: the last match seen is the youngest and wins.
    always_comb begin
        logic [AW-1:0] i;
        fwd_hit1 = 1'b0; fwd_stall1 = 1'b0; fwd_data1 = 32'b0;
        fwd_hit2 = 1'b0; fwd_stall2 = 1'b0; fwd_data2 = 32'b0;
        for (int k = 0; k < DEPTH; k++) begin
            i = rd_ptr + AW'(k);
            if (valid[i] & e_we[i] & (e_waddr[i] == fwd_raddr1) & (fwd_raddr1 != 5'd0)) begin
                fwd_hit1   = 1'b1;
                fwd_stall1 = e_load[i] & ~e_got[i];
                fwd_data1  = e_wdata[i];
            end
            if (valid[i] & e_we[i] & (e_waddr[i] == fwd_raddr2) & (fwd_raddr2 != 5'd0)) begin
                fwd_hit2   = 1'b1;
                fwd_stall2 = e_load[i] & ~e_got[i];
                fwd_data2  = e_wdata[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            rsp_ptr     <= '0;
            count       <= '0;
            discard_cnt <= '0;
            e_wait      <= '0;
            e_got       <= '0;
            e_load      <= '0;
            e_we        <= '0;
            e_ex        <= '0;
        end else begin
            if (dok_entry) begin
                e_got[rsp_idx] <= 1'b1;
                if (e_load[rsp_idx]) e_wdata[rsp_idx] <= ld_ext;
                rsp_ptr <= rsp_idx + AW'(1);
            end
            if (dok_discard) discard_cnt <= discard_cnt - (AW+1)'(1);
            if (flush) begin
                wr_ptr      <= '0;
                rd_ptr      <= '0;
                rsp_ptr     <= '0;
                count       <= '0;
                discard_cnt <= discard_cnt + pend - (AW+1)'(dok_discard | dok_entry);
            end else begin
                if (push) begin
                    e_wait[wr_ptr]    <= in_wait_data;
                    e_got[wr_ptr]     <= 1'b0;
                    e_load[wr_ptr]    <= in_res_from_mem;
                    e_we[wr_ptr]      <= in_rf_we;
                    e_ex[wr_ptr]      <= in_ex;
                    e_op[wr_ptr]      <= in_mem_op;
                    e_lane[wr_ptr]    <= in_alu_result[1:0];
                    e_waddr[wr_ptr]   <= in_rf_waddr;
                    e_wdata[wr_ptr]   <= in_alu_result;
                    e_payload[wr_ptr] <= in_payload;
                    wr_ptr            <= wr_ptr + AW'(1);
                end
                if (pop) rd_ptr <= rd_ptr + AW'(1);
                count <= count + (AW+1)'(push) - (AW+1)'(pop);
            end
        end
    end
endmodule

// File: tb/tb_memu_ooo_buffer.sv
// Directed bench for memu_ooo_buffer: load latency/extraction, full/backpressure, flush discard, forwarding, mem_ex, reset.
module tb_memu_ooo_buffer;
    localparam int DEPTH = 4;
    localparam int PW    = 128;

    logic          clk = 1'b0;
    logic          resetn, flush, in_valid, in_allowin, in_wait_data, in_res_from_mem;
    logic [3:0]    in_mem_op;
    logic [31:0]   in_alu_result;
    logic          in_rf_we, in_ex;
    logic [4:0]    in_rf_waddr;
    logic [PW-1:0] in_payload;
    logic          data_sram_data_ok;
    logic [31:0]   data_sram_rdata;
    logic          out_valid, wb_allowin, out_rf_we;
    logic [4:0]    out_rf_waddr;
    logic [31:0]   out_rf_wdata;
    logic [PW-1:0] out_payload;
    logic          mem_ex;
    logic [4:0]    fwd_raddr1, fwd_raddr2;
    logic          fwd_hit1, fwd_hit2, fwd_stall1, fwd_stall2;
    logic [31:0]   fwd_data1, fwd_data2;

    int tests = 0;
    int fails = 0;

    memu_ooo_buffer #(.DEPTH(DEPTH), .PAYLOAD_W(PW)) dut (
        .clk(clk), .resetn(resetn), .flush(flush),
        .in_valid(in_valid), .in_allowin(in_allowin), .in_wait_data(in_wait_data),
        .in_res_from_mem(in_res_from_mem), .in_mem_op(in_mem_op), .in_alu_result(in_alu_result),
        .in_rf_we(in_rf_we), .in_rf_waddr(in_rf_waddr), .in_ex(in_ex), .in_payload(in_payload),
        .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
        .out_valid(out_valid), .wb_allowin(wb_allowin), .out_rf_we(out_rf_we),
        .out_rf_waddr(out_rf_waddr), .out_rf_wdata(out_rf_wdata), .out_payload(out_payload),
        .mem_ex(mem_ex), .fwd_raddr1(fwd_raddr1), .fwd_raddr2(fwd_raddr2),
        .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2), .fwd_stall1(fwd_stall1), .fwd_stall2(fwd_stall2),
        .fwd_data1(fwd_data1), .fwd_data2(fwd_data2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic push_e(input logic wd, input logic ld, input logic [3:0] op, input logic [31:0] alu,
                          input logic we, input logic [4:0] wa, input logic ex);
        in_valid        = 1'b1;
        in_wait_data    = wd;
        in_res_from_mem = ld;
        in_mem_op       = op;
        in_alu_result   = alu;
        in_rf_we        = we;
        in_rf_waddr     = wa;
        in_ex           = ex;
        in_payload      = {96'h0, alu};
        tick();
        in_valid     = 1'b0;
        in_wait_data = 1'b0;
        in_ex        = 1'b0;
    endtask

    task automatic dok(input logic [31:0] d);
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = d;
        tick();
        data_sram_data_ok = 1'b0;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_b [4];
        exp_b = '{32'h00000001, 32'h0000007F, 32'hFFFFFFFF, 32'hFFFFFF80};
        resetn = 1'b0; flush = 1'b0; in_valid = 1'b0; in_wait_data = 1'b0; in_res_from_mem = 1'b0;
        in_mem_op = 4'd0; in_alu_result = 32'd0; in_rf_we = 1'b0; in_rf_waddr = 5'd0; in_ex = 1'b0;
        in_payload = '0; data_sram_data_ok = 1'b0; data_sram_rdata = 32'd0; wb_allowin = 1'b0;
        fwd_raddr1 = 5'd5; fwd_raddr2 = 5'd0;
        tick(); tick();
        resetn = 1'b1;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_allowin", 32'(in_allowin), 32'd1);
        chk("rst_mem_ex", 32'(mem_ex), 32'd0);
        chk("rst_fwd_hit1", 32'(fwd_hit1), 32'd0);
        chk("rst_fwd_stall1", 32'(fwd_stall1), 32'd0);

        // ld.w, data_ok two cycles after push
        push_e(1'b1, 1'b1, 4'd2, 32'h1000, 1'b1, 5'd3, 1'b0);
        #1; chk("ldw_wait", 32'(out_valid), 32'd0);
        tick();
        dok(32'hDEADBEEF);
        #1;
        chk("ldw_valid", 32'(out_valid), 32'd1);
        chk("ldw_wdata", out_rf_wdata, 32'hDEADBEEF);
        chk("ldw_waddr", 32'(out_rf_waddr), 32'd3);
        chk("ldw_payload", out_payload[31:0], 32'h1000);
        wb_allowin = 1'b1; tick(); wb_allowin = 1'b0;
        #1; chk("ldw_popped", 32'(out_valid), 32'd0);

        // four ld.b fill the buffer
        for (int k = 0; k < 4; k++) push_e(1'b1, 1'b1, 4'd0, 32'h100 + 32'(k), 1'b1, 5'd6, 1'b0);
        #1;
        chk("full_allowin", 32'(in_allowin), 32'd0);
        chk("full_wait", 32'(out_valid), 32'd0);
        for (int k = 0; k < 4; k++) dok(32'h80FF7F01);
        #1;
        chk("full_allowin_hold", 32'(in_allowin), 32'd0);
        chk("full_valid", 32'(out_valid), 32'd1);
        wb_allowin = 1'b1;
        #1; chk("full_pop_allowin", 32'(in_allowin), 32'd1);
        for (int k = 0; k < 4; k++) begin
            chk("ldb_wdata", out_rf_wdata, exp_b[k]);
            tick();
            #1;
        end
        wb_allowin = 1'b0;
        #1; chk("ldb_drained", 32'(out_valid), 32'd0);

        // flush with three loads pending and a data_ok in the same cycle
        for (int k = 0; k < 3; k++) push_e(1'b1, 1'b1, 4'd2, 32'h200, 1'b1, 5'd4, 1'b0);
        flush = 1'b1; data_sram_data_ok = 1'b1; data_sram_rdata = 32'h99;
        tick();
        flush = 1'b0; data_sram_data_ok = 1'b0;
        #1;
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_allowin", 32'(in_allowin), 32'd1);
        push_e(1'b1, 1'b1, 4'd9, 32'h2002, 1'b1, 5'd8, 1'b0);
        #1; chk("disc_allowin3", 32'(in_allowin), 32'd1);
        push_e(1'b0, 1'b0, 4'd0, 32'h55, 1'b1, 5'd7, 1'b0);
        #1; chk("disc_allowin4", 32'(in_allowin), 32'd0);
        dok(32'h11111111);
        #1;
        chk("disc1_valid", 32'(out_valid), 32'd0);
        chk("disc1_allowin", 32'(in_allowin), 32'd1);
        dok(32'h22222222);
        #1; chk("disc2_valid", 32'(out_valid), 32'd0);
        dok(32'hBEEF1234);
        #1;
        chk("ldhu_valid", 32'(out_valid), 32'd1);
        chk("ldhu_wdata", out_rf_wdata, 32'h0000BEEF);
        wb_allowin = 1'b1; tick();
        #1;
        chk("add_valid", 32'(out_valid), 32'd1);
        chk("add_wdata", out_rf_wdata, 32'h55);
        tick(); wb_allowin = 1'b0;
        #1; chk("disc_drained", 32'(out_valid), 32'd0);

        // forwarding: add r5 then ld r5
        push_e(1'b0, 1'b0, 4'd0, 32'h12345678, 1'b1, 5'd5, 1'b0);
        push_e(1'b1, 1'b1, 4'd2, 32'h2000, 1'b1, 5'd5, 1'b0);
        fwd_raddr1 = 5'd5; fwd_raddr2 = 5'd3;
        #1;
        chk("fwd_hit1", 32'(fwd_hit1), 32'd1);
        chk("fwd_stall1", 32'(fwd_stall1), 32'd1);
        chk("fwd_hit2_miss", 32'(fwd_hit2), 32'd0);
        dok(32'hCAFEF00D);
        #1;
        chk("fwd_hit1_after", 32'(fwd_hit1), 32'd1);
        chk("fwd_stall1_after", 32'(fwd_stall1), 32'd0);
        chk("fwd_data1", fwd_data1, 32'hCAFEF00D);
        fwd_raddr1 = 5'd0;
        #1; chk("fwd_r0", 32'(fwd_hit1), 32'd0);
        flush = 1'b1; tick(); flush = 1'b0;

        // mem_ex set by an exception entry, cleared by pop then by flush
        push_e(1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 5'd0, 1'b1);
        #1; chk("memex_set", 32'(mem_ex), 32'd1);
        wb_allowin = 1'b1; tick(); wb_allowin = 1'b0;
        #1; chk("memex_pop", 32'(mem_ex), 32'd0);
        push_e(1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 5'd0, 1'b1);
        #1; chk("memex_set2", 32'(mem_ex), 32'd1);
        flush = 1'b1; tick(); flush = 1'b0;
        #1; chk("memex_flush", 32'(mem_ex), 32'd0);

        // stray data_ok is ignored; the next load gets its own data
        dok(32'h77777777);
        push_e(1'b1, 1'b1, 4'd2, 32'h3000, 1'b1, 5'd9, 1'b0);
        tick();
        dok(32'h13572468);
        #1;
        chk("stray_valid", 32'(out_valid), 32'd1);
        chk("stray_wdata", out_rf_wdata, 32'h13572468);
        push_e(1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 5'd0, 1'b1);
        fwd_raddr1 = 5'd9;
        #1;
        chk("pre_rst_hit1", 32'(fwd_hit1), 32'd1);
        chk("pre_rst_memex", 32'(mem_ex), 32'd1);
        resetn = 1'b0; tick(); resetn = 1'b1;
        #1;
        chk("rst2_out_valid", 32'(out_valid), 32'd0);
        chk("rst2_in_allowin", 32'(in_allowin), 32'd1);
        chk("rst2_mem_ex", 32'(mem_ex), 32'd0);
        chk("rst2_fwd_hit1", 32'(fwd_hit1), 32'd0);
        chk("rst2_fwd_stall1", 32'(fwd_stall1), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
